// File: rtl/rca_key_pipe_stage.sv
// Key loader and two-stage operand/result pipeline wrapped around a key-locked 32-bit ripple carry adder.
// Optional build macro RCA_KEY_LOCK_EN makes the committed key write-once until reset.
module rca_key_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int KEY_W   = 64,
  parameter int CHUNK_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                key_start_i,
  input  logic [CHUNK_W-1:0]  key_data_i,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  output logic                key_loaded_o,
  output logic [KEY_W-1:0]    keyinput_o,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [DATA_W-1:0]   add1_i,
  input  logic [DATA_W-1:0]   add2_i,
  output logic [DATA_W-1:0]   add1_o,
  output logic [DATA_W-1:0]   add2_o,
  input  logic [DATA_W:0]     result_i,
  output logic [DATA_W:0]     result_o,
  output logic                res_valid_o,
  input  logic                res_ready_i
);

  localparam int BEATS = KEY_W / CHUNK_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [KEY_W-1:0]    shadow_q, shadow_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                key_loaded_q, key_loaded_d;
  logic                reload_pend_q, reload_pend_d;
  logic [DATA_W-1:0]   add1_q, add1_d;
  logic [DATA_W-1:0]   add2_q, add2_d;
  logic                s1_valid_q, s1_valid_d;
  logic [DATA_W:0]     result_q, result_d;
  logic                res_valid_q, res_valid_d;

  logic                start_ok;
  logic                beat_acc;
  logic                last_beat;
  logic                adv2;
  logic                op_acc;
  logic                pipe_empty;

  // Once a key is committed in the locked build, further load requests are dead.
`ifdef RCA_KEY_LOCK_EN
  assign start_ok = key_start_i & ~key_loaded_q;
`else
  assign start_ok = key_start_i;
`endif

  assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign pipe_empty = ~s1_valid_q & ~res_valid_q;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default at the top of the block so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_LOAD;
      ST_LOAD:  if (beat_acc && last_beat) state_d = ST_READY;
      ST_READY: if (reload_pend_q && pipe_empty) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / handshake logic derived from the current state.
  always_comb begin
    key_ready_o = 1'b0;
    beat_acc    = 1'b0;
    adv2        = ~res_valid_q | res_ready_i;
    op_ready_o  = 1'b0;
    if (state_q == ST_LOAD) begin
      key_ready_o = 1'b1;
      // A restart in the same cycle as a beat drops the beat.
      beat_acc    = key_valid_i & ~start_ok;
    end
    if (state_q == ST_READY) begin
      op_ready_o = ~reload_pend_q & (~s1_valid_q | adv2);
    end
    op_acc = op_valid_i & op_ready_o;
  end

  // Key shadow, commit and reload bookkeeping.
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    shadow_d      = shadow_q;
    key_d         = key_q;
    key_loaded_d  = key_loaded_q;
    reload_pend_d = reload_pend_q;
    if (state_q == ST_LOAD) begin
      if (start_ok) begin
        beat_cnt_d = '0;
        shadow_d   = '0;
      end else if (beat_acc) begin
        shadow_d[beat_cnt_q*CHUNK_W +: CHUNK_W] = key_data_i;
        if (last_beat) begin
          key_d        = shadow_d;
          key_loaded_d = 1'b1;
          beat_cnt_d   = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
    if (state_q == ST_READY) begin
      if (state_d == ST_LOAD) reload_pend_d = 1'b0;
      else if (start_ok)      reload_pend_d = 1'b1;
    end
  end

  // Operand stage and result stage; s1 and the result register stall together.
  always_comb begin
    add1_d      = add1_q;
    add2_d      = add2_q;
    s1_valid_d  = s1_valid_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    if (adv2) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) result_d = result_i;
      s1_valid_d = 1'b0;
    end
    if (op_acc) begin
      add1_d     = add1_i;
      add2_d     = add2_i;
      s1_valid_d = 1'b1;
    end
  end

  // NOTE: the key shadow is a plain register bank rather than a memory, and it is
  // cleared on reset so no stale key bits survive a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q    <= '0;
      shadow_q      <= '0;
      key_q         <= '0;
      key_loaded_q  <= 1'b0;
      reload_pend_q <= 1'b0;
      add1_q        <= '0;
      add2_q        <= '0;
      s1_valid_q    <= 1'b0;
      result_q      <= '0;
      res_valid_q   <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      shadow_q      <= shadow_d;
      key_q         <= key_d;
      key_loaded_q  <= key_loaded_d;
      reload_pend_q <= reload_pend_d;
      add1_q        <= add1_d;
      add2_q        <= add2_d;
      s1_valid_q    <= s1_valid_d;
      result_q      <= result_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign keyinput_o   = key_q;
  assign key_loaded_o = key_loaded_q;
  assign add1_o       = add1_q;
  assign add2_o       = add2_q;
  assign result_o     = result_q;
  assign res_valid_o  = res_valid_q;

endmodule

// File: tb/tb_rca_key_pipe_stage.sv
// Directed bench for rca_key_pipe_stage: table-driven key load plus hand-written pipeline,
// reload and reset sequences. Define RCA_KEY_LOCK_EN for both files to test the locked build.
module tb_rca_key_pipe_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        key_start_i;
  logic [7:0]  key_data_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic        key_loaded_o;
  logic [63:0] keyinput_o;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [31:0] add1_i, add2_i, add1_o, add2_o;
  logic [32:0] result_i, result_o;
  logic        res_valid_o;
  logic        res_ready_i;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_cons   = 0;
  logic [32:0] exp_q[$];

  localparam logic [63:0] KEY1 = 64'h0807060504030201;
  localparam logic [63:0] KEY2 = 64'hA7A6A5A4A3A2A1A0;

  always #5 clk_i = ~clk_i;

  // Adder model driven back into the block.
  assign result_i = {1'b0, add1_o} + {1'b0, add2_o};

  rca_key_pipe_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .key_start_i(key_start_i), .key_data_i(key_data_i), .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o), .key_loaded_o(key_loaded_o), .keyinput_o(keyinput_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .add1_o(add1_o), .add2_o(add2_o),
    .result_i(result_i), .result_o(result_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
  );

  typedef struct {
    logic        start;
    logic        kvalid;
    logic [7:0]  kdata;
    logic        opv;
    logic        exp_kready;
    logic        exp_loaded;
    logic [63:0] exp_key;
    logic        exp_opready;
  } key_vec_t;

  key_vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Samples handshakes mid-cycle, scoreboards consumed results, then advances one edge.
  task automatic tick();
    @(negedge clk_i);
    if (op_valid_i && op_ready_o) begin
      exp_q.push_back({1'b0, add1_i} + {1'b0, add2_i});
      n_acc++;
    end
    if (res_valid_o && res_ready_i) begin
      n_cons++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h expected=none", result_o);
      end else begin
        check("sb_result", result_o, exp_q.pop_front());
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; key_start_i = 0; key_data_i = 0; key_valid_i = 0;
    op_valid_i = 0; add1_i = 0; add2_i = 0; res_ready_i = 1'b1;

    vecs[0] = '{start: 1'b1, kvalid: 1'b0, kdata: 8'h00, opv: 1'b1,
                exp_kready: 1'b1, exp_loaded: 1'b0, exp_key: 64'h0, exp_opready: 1'b0};
    for (int i = 1; i <= 8; i++) begin
      vecs[i] = '{start: 1'b0, kvalid: 1'b1, kdata: 8'(i), opv: 1'b1,
                  exp_kready: (i < 8), exp_loaded: (i == 8),
                  exp_key: (i == 8) ? KEY1 : 64'h0, exp_opready: (i == 8)};
    end

    // Reset state
    tick(); tick();
    check("rst_key", keyinput_o, 64'h0);
    check("rst_loaded", key_loaded_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_add1", add1_o, 0);
    rst_i = 1'b0;
    tick();
    check("idle_key_ready", key_ready_o, 0);
    check("idle_op_ready", op_ready_o, 0);

    // Key load table, with operands offered before any key exists
    for (int i = 0; i < 9; i++) begin
      key_start_i = vecs[i].start;
      key_valid_i = vecs[i].kvalid;
      key_data_i  = vecs[i].kdata;
      op_valid_i  = vecs[i].opv;
      tick();
      check($sformatf("v%0d_key_ready", i), key_ready_o, vecs[i].exp_kready);
      check($sformatf("v%0d_loaded", i), key_loaded_o, vecs[i].exp_loaded);
      check($sformatf("v%0d_key", i), keyinput_o, vecs[i].exp_key);
      check($sformatf("v%0d_op_ready", i), op_ready_o, vecs[i].exp_opready);
      check($sformatf("v%0d_res_valid", i), res_valid_o, 0);
    end
    key_start_i = 0; key_valid_i = 0; op_valid_i = 0;
    check("pre_key_accepts", n_acc, 0);

    // Single op with carry out, 2-edge latency
    add1_i = 32'hFFFF_FFFF; add2_i = 32'h1; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    check("carry_accepted", n_acc, 1);
    check("carry_add1_o", add1_o, 32'hFFFF_FFFF);
    check("carry_add2_o", add2_o, 32'h1);
    check("carry_valid_e1", res_valid_o, 0);
    tick();
    check("carry_valid_e2", res_valid_o, 1);
    check("carry_result", result_o, 33'h1_0000_0000);
    tick();
    check("carry_drained", res_valid_o, 0);

    // Backpressure: 4 stalled cycles accept exactly 2 ops
    res_ready_i = 1'b0; n_acc = 0; n_cons = 0;
    for (int k = 0; k < 4; k++) begin
      add1_i = 32'h8000_0000 + 32'(k); add2_i = 32'h8000_0000; op_valid_i = 1'b1;
      tick();
    end
    check("bp_accepted", n_acc, 2);
    check("bp_valid_held", res_valid_o, 1);
    check("bp_result_held", result_o, 33'h1_0000_0000);
    check("bp_add1_held", add1_o, 32'h8000_0001);
    check("bp_op_ready", op_ready_o, 0);
    op_valid_i = 1'b0; res_ready_i = 1'b1;
    tick();
    check("bp_second_result", result_o, 33'h1_0000_0001);
    check("bp_second_valid", res_valid_o, 1);
    tick();
    check("bp_empty", res_valid_o, 0);
    check("bp_consumed", n_cons, 2);

    // Back-to-back ops with continuous consumption: no bubbles
    n_acc = 0; n_cons = 0;
    for (int k = 0; k < 4; k++) begin
      add1_i = 32'(k * 3); add2_i = 32'd7; op_valid_i = 1'b1;
      tick();
    end
    op_valid_i = 1'b0;
    tick(); tick();
    check("stream_accepted", n_acc, 4);
    check("stream_consumed", n_cons, 4);

`ifdef RCA_KEY_LOCK_EN
    // Locked build: second load request is ignored
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
    check("lock_key_ready", key_ready_o, 0);
    check("lock_op_ready", op_ready_o, 1);
    for (int i = 0; i < 8; i++) begin
      key_valid_i = 1'b1; key_data_i = 8'hA0 + 8'(i);
      tick();
      check($sformatf("lock_b%0d_ready", i), key_ready_o, 0);
    end
    key_valid_i = 1'b0;
    check("lock_key", keyinput_o, KEY1);
`else
    // Reload: pending request blocks ops, then 3 beats, restart (with a dropped beat), new key
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
    check("rl_pend_op_ready", op_ready_o, 0);
    check("rl_pend_key_ready", key_ready_o, 0);
    tick();
    check("rl_load_key_ready", key_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      key_valid_i = 1'b1; key_data_i = 8'h11 * 8'(i + 1);
      tick();
    end
    key_start_i = 1'b1; key_data_i = 8'h44;
    tick();
    key_start_i = 1'b0;
    check("rl_restart_key", keyinput_o, KEY1);
    for (int i = 0; i < 8; i++) begin
      key_data_i = 8'hA0 + 8'(i);
      tick();
      check($sformatf("rl_b%0d_key", i), keyinput_o, (i == 7) ? KEY2 : KEY1);
      check($sformatf("rl_b%0d_loaded", i), key_loaded_o, 1);
    end
    key_valid_i = 1'b0;
    check("rl_key_ready_done", key_ready_o, 0);
    check("rl_op_ready_done", op_ready_o, 1);
`endif

    // Reset with a held result
    res_ready_i = 1'b0; add1_i = 32'd5; add2_i = 32'd6; op_valid_i = 1'b1;
    tick();
    op_valid_i = 1'b0;
    tick();
    check("mid_res_valid", res_valid_o, 1);
    check("mid_result", result_o, 33'd11);
    rst_i = 1'b1;
    tick();
    check("rr_res_valid", res_valid_o, 0);
    check("rr_loaded", key_loaded_o, 0);
    check("rr_key", keyinput_o, 64'h0);
    check("rr_result", result_o, 0);
    check("rr_add1", add1_o, 0);
    check("rr_op_ready", op_ready_o, 0);
    rst_i = 1'b0;
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
